// File: rtl/pre_if_stage_pkg.sv
// Shared pipeline definitions for the PC-generation (pre-IF) stage and the
// fetch stage that consumes its output bundle.
package pre_if_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pre_if_state_e;

  // pre-IF -> IF bundle; the fetch stage input port reuses this type.
  typedef struct packed {
    logic [31:0] pc;
  } toif_bits_t;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pre_if_stage_if.sv
// pre-IF -> IF handshake plus the instruction SRAM request bus driven by the
// PC-generation stage.
interface pre_if_stage_if;
  import pre_if_stage_pkg::*;

  logic        toif_valid;
  logic        toif_ready;
  toif_bits_t  toif_bits;
  logic        inst_sram_en;
  logic        inst_sram_wr;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;

  modport master (
    output toif_valid,
    output toif_bits,
    output inst_sram_en,
    output inst_sram_wr,
    output inst_sram_addr,
    output inst_sram_wdata,
    output inst_sram_wstrb,
    input  toif_ready
  );

  modport slave (
    input  toif_valid,
    input  toif_bits,
    input  inst_sram_en,
    input  inst_sram_wr,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    input  inst_sram_wstrb,
    output toif_ready
  );

endinterface

// File: rtl/pre_if_stage.sv
// PC-generation stage: holds the fetch PC, issues the SRAM read address one
// cycle ahead, applies trap/branch redirects and stops on halt.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  pre_if_stage_if.master        toif,
  input  logic                  br_valid,
  input  logic [31:0]           br_target,
  input  logic                  trap_valid,
  input  logic [31:0]           trap_target,
  input  logic                  halt_valid,
  output logic [31:0]           fetch_cnt
);

  pre_if_state_e state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   next_pc;
  logic [31:0]   fetch_cnt_q;
  logic          valid_c;
  logic          sram_en_c;
  logic          fire;

  // Next-state, next_pc mux and output decode; reset forces valid/enable low.
  always_comb begin
    state_d   = state_q;
    next_pc   = pc_q;
    valid_c   = 1'b0;
    sram_en_c = 1'b0;
    fire      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        sram_en_c = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        valid_c   = 1'b1;
        sram_en_c = 1'b1;
        fire      = toif.toif_ready;
        if (trap_valid)    next_pc = align_target(trap_target);
        else if (br_valid) next_pc = align_target(br_target);
        else if (fire)     next_pc = pc_q + 32'd4;
        if (halt_valid)    state_d = ST_HALT;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    if (!reset) begin
      valid_c   = 1'b0;
      sram_en_c = 1'b0;
      fire      = 1'b0;
    end
  end

  // State, PC and accepted-PC counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      if (fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign toif.toif_valid      = valid_c;
  assign toif.toif_bits.pc    = pc_q;
  assign toif.inst_sram_en    = sram_en_c;
  assign toif.inst_sram_wr    = 1'b0;
  assign toif.inst_sram_addr  = next_pc;
  assign toif.inst_sram_wdata = '0;
  assign toif.inst_sram_wstrb = '0;
  assign fetch_cnt            = fetch_cnt_q;

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: per-cycle vector table plus a
// scoreboard of accepted PCs, followed by reset and counter-wrap sequences.
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  typedef struct {
    logic        ready;
    logic        br_v;
    logic [31:0] br_t;
    logic        trap_v;
    logic [31:0] trap_t;
    logic        halt;
    logic        exp_valid;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_valid;
  logic [31:0] fetch_cnt;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] sb_q[$];
  vec_t        vecs[24];

  pre_if_stage_if bus ();

  pre_if_stage #(.RESET_PC(RPC)) dut (
    .clock       (clock),
    .reset       (reset),
    .toif        (bus),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .halt_valid  (halt_valid),
    .fetch_cnt   (fetch_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pops the expected PC for every accepted handshake seen this cycle.
  task automatic sb_mon();
    if (bus.toif_valid === 1'b1 && bus.toif_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_fire actual=%h required=none", bus.toif_bits.pc);
      end else begin
        chk("sb_fire_pc", bus.toif_bits.pc, sb_q.pop_front());
      end
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic bv, input logic [31:0] bt,
                              input logic tv, input logic [31:0] tt, input logic h,
                              input logic ev, input logic een, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic [31:0] ecnt);
    vec_t v;
    v.ready = rdy; v.br_v = bv; v.br_t = bt; v.trap_v = tv; v.trap_t = tt; v.halt = h;
    v.exp_valid = ev; v.exp_en = een; v.exp_pc = epc; v.exp_addr = eaddr; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic bv, input logic [31:0] bt,
                       input logic tv, input logic [31:0] tt, input logic h);
    bus.toif_ready = rdy;
    br_valid = bv; br_target = bt;
    trap_valid = tv; trap_target = tt;
    halt_valid = h;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    // boot and steady streaming
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 1, RPC,            RPC,            0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0,  1, 1, RPC,            32'h8000_0004,  0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0004,  32'h8000_0008,  1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0008,  32'h8000_000C,  2);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_000C,  32'h8000_0010,  3);
    // branch back to _0008 while stalled, then stall there three cycles
    vecs[5]  = mk(0, 1, 32'h8000_0008, 0, 0, 0,  1, 1, 32'h8000_0010, 32'h8000_0008, 4);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0008,  32'h8000_0008,  4);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0008,  32'h8000_0008,  4);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0008,  32'h8000_0008,  4);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0008,  32'h8000_000C,  4);
    vecs[10] = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_000C,  32'h8000_0010,  5);
    // branch with fire, then branch without acceptance
    vecs[11] = mk(1, 1, 32'h8000_0103, 0, 0, 0,  1, 1, 32'h8000_0010, 32'h8000_0100, 6);
    vecs[12] = mk(0, 1, 32'h8000_0207, 0, 0, 0,  1, 1, 32'h8000_0100, 32'h8000_0204, 7);
    vecs[13] = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_0204,  32'h8000_0208,  7);
    // trap beats branch beats +4
    vecs[14] = mk(1, 1, 32'h8000_2000, 1, 32'h8000_1000, 0,  1, 1, 32'h8000_0208, 32'h8000_1000, 8);
    vecs[15] = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h8000_1000,  32'h8000_1004,  9);
    // misaligned target near top of address space, then pc wrap
    vecs[16] = mk(1, 1, 32'hFFFF_FFFE, 0, 0, 0,  1, 1, 32'h8000_1004, 32'hFFFF_FFFC, 10);
    vecs[17] = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'hFFFF_FFFC,  32'h0000_0000,  11);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h0000_0000,  32'h0000_0000,  12);
    vecs[19] = mk(0, 0, 0, 1, 32'h0000_0042, 0,  1, 1, 32'h0000_0000, 32'h0000_0040, 12);
    vecs[20] = mk(1, 0, 0, 0, 0, 0,  1, 1, 32'h0000_0040,  32'h0000_0044,  12);
    // halt with branch: pc still updates, then everything frozen
    vecs[21] = mk(1, 1, 32'h8000_3000, 0, 0, 1,  1, 1, 32'h0000_0044, 32'h8000_3000, 13);
    vecs[22] = mk(1, 1, 32'h8000_4000, 0, 0, 0,  0, 0, 32'h8000_3000, 32'h8000_3000, 14);
    vecs[23] = mk(1, 0, 0, 1, 32'h8000_5000, 1,  0, 0, 32'h8000_3000, 32'h8000_3000, 14);

    // held in reset
    @(negedge clock);
    chk("rst_valid", {31'b0, bus.toif_valid}, 32'd0);
    chk("rst_en", {31'b0, bus.inst_sram_en}, 32'd0);
    chk("rst_pc", bus.toif_bits.pc, RPC);
    chk("rst_cnt", fetch_cnt, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ready, vecs[i].br_v, vecs[i].br_t, vecs[i].trap_v, vecs[i].trap_t, vecs[i].halt);
      if (vecs[i].ready && vecs[i].exp_valid) sb_q.push_back(vecs[i].exp_pc);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, bus.toif_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_en", i), {31'b0, bus.inst_sram_en}, {31'b0, vecs[i].exp_en});
      chk($sformatf("v%0d_pc", i), bus.toif_bits.pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_addr", i), bus.inst_sram_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_cnt", i), fetch_cnt, vecs[i].exp_cnt);
      chk($sformatf("v%0d_wr", i), {bus.inst_sram_wdata[30:0], bus.inst_sram_wr}, 32'd0);
      chk($sformatf("v%0d_wstrb", i), {28'd0, bus.inst_sram_wstrb}, 32'd0);
      sb_mon();
      @(negedge clock);
    end

    // restart from HALT through reset
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    #1;
    chk("hrst_valid", {31'b0, bus.toif_valid}, 32'd0);
    chk("hrst_en", {31'b0, bus.inst_sram_en}, 32'd0);
    @(negedge clock);
    chk("hrst_pc", bus.toif_bits.pc, RPC);
    chk("hrst_cnt", fetch_cnt, 32'd0);
    reset = 1'b1;
    #1;
    chk("hboot_valid", {31'b0, bus.toif_valid}, 32'd0);
    chk("hboot_en", {31'b0, bus.inst_sram_en}, 32'd1);
    chk("hboot_addr", bus.inst_sram_addr, RPC);
    @(negedge clock);
    sb_q.push_back(RPC);
    #1;
    chk("hrun_valid", {31'b0, bus.toif_valid}, 32'd1);
    chk("hrun_addr", bus.inst_sram_addr, 32'h8000_0004);
    sb_mon();
    @(negedge clock);
    chk("hrun_pc2", bus.toif_bits.pc, 32'h8000_0004);
    chk("hrun_cnt", fetch_cnt, 32'd1);

    // reset asserted with a pending fire and branch
    drive(1'b1, 1'b1, 32'h8000_5000, 1'b0, '0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, bus.toif_valid}, 32'd0);
    sb_mon();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("mrst_pc", bus.toif_bits.pc, RPC);
    chk("mrst_cnt", fetch_cnt, 32'd0);
    chk("mrst_boot_valid", {31'b0, bus.toif_valid}, 32'd0);
    @(negedge clock);

    // counter wrap from a preloaded all-ones value
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    #1;
    chk("wrap_pre", fetch_cnt, 32'hFFFF_FFFF);
    bus.toif_ready = 1'b1;
    sb_q.push_back(RPC);
    #1;
    sb_mon();
    @(negedge clock);
    bus.toif_ready = 1'b0;
    #1;
    chk("wrap_cnt", fetch_cnt, 32'd0);
    chk("wrap_pc", bus.toif_bits.pc, 32'h8000_0004);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
